ochan_allocator: RTL and testbench

//   Wormhole switch allocator for one router output channel (index OUT_CHAN_ID).

---
 rtl/noc_pkg.sv | 24 ++
 rtl/ochan_allocator_rr_arbiter.sv | 57 +++++
 rtl/ochan_allocator.sv | 153 +++++++++++++++
 tb/tb_ochan_allocator.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the router output-channel allocator.
//   - flit-type encodings carried in the per-input flit_id field
//   - default flit-id field width
//   - allocator FSM state type
//   - sel_width(): index width for a count of n items (never below 1 bit)
package noc_pkg;

    localparam int FLIT_ID_W_DFLT = 2;

    localparam logic [1:0] FLIT_BODY      = 2'b00;
    localparam logic [1:0] FLIT_HEAD      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alloc_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ochan_allocator_rr_arbiter.sv
// rr_arbiter: combinational single-winner arbiter.
//   Build option ALLOC_RR_EN:
//     defined   - round-robin; search starts at ptr and moves upward with wrap
//     undefined - fixed priority; lowest requesting index wins, ptr ignored
// Ports:
//   req  in  N   request vector
//   ptr  in  W   round-robin start index (always < N)
//   gnt  out N   one-hot grant (all zero when no request)
//   idx  out W   encoded winner index (0 when no request)
//   any  out 1   at least one request present
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N = 5,
    parameter int W = sel_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [2*N-1:0] req_dbl_s;
    logic [N-1:0]   req_rot_s;
    logic [N-1:0]   first_s;
    logic [W-1:0]   off_s;
    logic [W:0]     sum_s;
    logic           unused_ptr_s;

    // Rotate requests so the search origin sits at bit 0, isolate the lowest
    // set bit, encode its offset, then add the origin back modulo N.
    always_comb begin
`ifdef ALLOC_RR_EN
        req_dbl_s    = {req, req} >> ptr;
        unused_ptr_s = 1'b0;
`else
        req_dbl_s    = {{N{1'b0}}, req};
        unused_ptr_s = ^ptr;
`endif
        req_rot_s = req_dbl_s[N-1:0];
        first_s   = req_rot_s & (~req_rot_s + {{(N-1){1'b0}}, 1'b1});
        off_s     = '0;
        for (int i = 0; i < N; i++) begin
            off_s = off_s | (first_s[i] ? W'(i) : '0);
        end
`ifdef ALLOC_RR_EN
        sum_s = {1'b0, ptr} + {1'b0, off_s};
`else
        sum_s = {1'b0, off_s};
`endif
        idx = (sum_s >= (W+1)'(N)) ? W'(sum_s - (W+1)'(N)) : sum_s[W-1:0];
        any = |req;
        gnt = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/ochan_allocator.sv
// ochan_allocator: wormhole switch allocator for a single router output.
//   Collects route results from IN_N inputs, arbitrates among head flits that
//   target OUT_CHAN_ID, locks the winner until its tail flit transfers, and
//   drives the crossbar select plus the pop strobe of the owning input VC.
//   Build option ALLOC_RR_EN: round-robin arbitration (pointer advances past
//   the owner on packet release); undefined gives fixed lowest-index priority.
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous reset, active-high
//   rtr_res_i      in   per-input requested output index
//   rtr_res_vld_i  in   per-input route valid (lowest bit of each slice used)
//   flit_id_i      in   per-input head-of-queue flit type
//   data_vld_i     in   per-input flit present
//   ochan_rdy_i    in   downstream can accept a flit
//   sel_o          out  crossbar select (owning input)
//   out_vld_o      out  selected flit valid toward the output
//   chan_alloc_o   out  one-hot pop strobe to the owning input VC
module ochan_allocator
    import noc_pkg::*;
#(
    parameter int IN_N        = 5,
    parameter int OUT_M       = 5,
    parameter int FLIT_ID_W   = FLIT_ID_W_DFLT,
    parameter int OUT_CHAN_ID = 0,
    localparam int CHAN_SEL_W = sel_width(IN_N),
    localparam int RTR_RES_W  = sel_width(OUT_M)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [IN_N*RTR_RES_W-1:0] rtr_res_i,
    input  logic [IN_N*RTR_RES_W-1:0] rtr_res_vld_i,
    input  logic [IN_N*FLIT_ID_W-1:0] flit_id_i,
    input  logic [IN_N-1:0]           data_vld_i,
    input  logic                      ochan_rdy_i,
    output logic [CHAN_SEL_W-1:0]     sel_o,
    output logic                      out_vld_o,
    output logic [IN_N-1:0]           chan_alloc_o
);

    localparam logic [FLIT_ID_W-1:0] ID_HEAD      = FLIT_ID_W'(FLIT_HEAD);
    localparam logic [FLIT_ID_W-1:0] ID_TAIL      = FLIT_ID_W'(FLIT_TAIL);
    localparam logic [FLIT_ID_W-1:0] ID_HEAD_TAIL = FLIT_ID_W'(FLIT_HEAD_TAIL);

    alloc_state_e           state_r;
    logic [CHAN_SEL_W-1:0]  owner_r;
    logic [CHAN_SEL_W-1:0]  ptr_s;
    logic [FLIT_ID_W-1:0]   id_s [IN_N];
    logic [IN_N-1:0]        req_s;
    logic [IN_N-1:0]        unused_gnt_s;
    logic [CHAN_SEL_W-1:0]  win_idx_s;
    logic                   any_req_s;
    logic                   own_vld_s;
    logic [FLIT_ID_W-1:0]   own_id_s;
    logic                   xfer_s;
    logic                   tail_s;
    logic                   unused_route_vld_s;

`ifdef ALLOC_RR_EN
    logic [CHAN_SEL_W-1:0]  ptr_r;
    assign ptr_s = ptr_r;
`else
    assign ptr_s = '0;
`endif

    // Per-input request: valid route to this output with a head flit waiting.
    always_comb begin
        req_s              = '0;
        unused_route_vld_s = 1'b0;
        for (int i = 0; i < IN_N; i++) begin
            id_s[i]  = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
            req_s[i] = rtr_res_vld_i[i*RTR_RES_W]
                     & (rtr_res_i[i*RTR_RES_W +: RTR_RES_W] == RTR_RES_W'(OUT_CHAN_ID))
                     & data_vld_i[i]
                     & ((id_s[i] == ID_HEAD) | (id_s[i] == ID_HEAD_TAIL));
            // Only the lowest bit of each route-valid slice carries meaning.
            for (int b = 1; b < RTR_RES_W; b++) begin
                unused_route_vld_s = unused_route_vld_s ^ rtr_res_vld_i[i*RTR_RES_W + b];
            end
        end
    end

    rr_arbiter #(
        .N (IN_N),
        .W (CHAN_SEL_W)
    ) u_arb (
        .req (req_s),
        .ptr (ptr_s),
        .gnt (unused_gnt_s),
        .idx (win_idx_s),
        .any (any_req_s)
    );

    // Owner-side view: valid, flit type, and whether this cycle moves a tail.
    always_comb begin
        own_vld_s = data_vld_i[owner_r];
        own_id_s  = id_s[owner_r];
        xfer_s    = (state_r == ST_BUSY) & own_vld_s & ochan_rdy_i;
        tail_s    = (own_id_s == ID_TAIL) | (own_id_s == ID_HEAD_TAIL);
    end

    // Output drive: silent in IDLE, mirror the owner's valid while BUSY.
    always_comb begin
        out_vld_o    = 1'b0;
        chan_alloc_o = '0;
        if (state_r == ST_BUSY) begin
            out_vld_o             = own_vld_s;
            chan_alloc_o[owner_r] = own_vld_s & ochan_rdy_i;
        end else begin
            out_vld_o    = 1'b0;
            chan_alloc_o = '0;
        end
    end

    // sel_o is the owner register itself, so it holds through IDLE.
    assign sel_o = owner_r;

    // Allocation FSM: grant in IDLE, hold the lock until a tail transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            owner_r <= '0;
`ifdef ALLOC_RR_EN
            ptr_r   <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_r <= win_idx_s;
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (xfer_s && tail_s) begin
                        state_r <= ST_IDLE;
`ifdef ALLOC_RR_EN
                        ptr_r   <= (owner_r == CHAN_SEL_W'(IN_N-1)) ? '0
                                 : owner_r + CHAN_SEL_W'(1);
`endif
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ochan_allocator.sv
// Self-checking bench for ochan_allocator (default parameters: 5 inputs,
// output 0). Inputs are driven 1ns after the rising edge and outputs are
// sampled on the falling edge against a channel-ownership reference model.
module tb_ochan_allocator;

    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] HT   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] rtr_res;
    logic [14:0] rtr_res_vld;
    logic [9:0]  flit_id;
    logic [4:0]  data_vld;
    logic        rdy;
    logic [2:0]  sel;
    logic        out_vld;
    logic [4:0]  alloc;

    int          in_res [5];
    bit          in_rv  [5];
    logic [1:0]  in_id  [5];
    bit          in_dv  [5];

    // reference model: is the channel locked, by whom, where the search starts
    bit          m_busy;
    int          m_owner;
    int          m_ptr;

    logic [2:0]  obs_sel;
    logic        obs_vld;
    logic [4:0]  obs_alloc;

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ochan_allocator dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rtr_res_i     (rtr_res),
        .rtr_res_vld_i (rtr_res_vld),
        .flit_id_i     (flit_id),
        .data_vld_i    (data_vld),
        .ochan_rdy_i   (rdy),
        .sel_o         (sel),
        .out_vld_o     (out_vld),
        .chan_alloc_o  (alloc)
    );

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            rtr_res[i*3 +: 3]         = 3'(in_res[i]);
            rtr_res_vld[i*3]          = in_rv[i];
            rtr_res_vld[i*3+1 +: 2]   = 2'($urandom_range(0, 3));
            flit_id[i*2 +: 2]         = in_id[i];
            data_vld[i]               = in_dv[i];
        end
    endtask

    task automatic set_idle();
        for (int i = 0; i < 5; i++) begin
            in_res[i] = 0;
            in_rv[i]  = 1'b0;
            in_id[i]  = BODY;
            in_dv[i]  = 1'b0;
        end
        rdy = 1'b1;
    endtask

    task automatic put(input int i, input logic [1:0] id, input int res);
        in_res[i] = res;
        in_rv[i]  = 1'b1;
        in_id[i]  = id;
        in_dv[i]  = 1'b1;
    endtask

    task automatic clr(input int i);
        in_rv[i] = 1'b0;
        in_dv[i] = 1'b0;
    endtask

    function automatic int pick_winner();
        int w;
        w = -1;
`ifdef ALLOC_RR_EN
        for (int k = 4; k >= 0; k--) begin
            int c;
            c = (m_ptr + k) % 5;
            if (in_rv[c] && in_res[c] == 0 && in_dv[c] && (in_id[c] == HEAD || in_id[c] == HT))
                w = c;
        end
`else
        for (int c = 4; c >= 0; c--) begin
            if (in_rv[c] && in_res[c] == 0 && in_dv[c] && (in_id[c] == HEAD || in_id[c] == HT))
                w = c;
        end
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
    endtask

    // One clock: apply inputs, compare at the falling edge, advance the model.
    task automatic cycle(input string tag);
        logic [2:0] e_sel;
        logic       e_vld;
        logic [4:0] e_alloc;
        int         w;
        drive();
        @(negedge clk);
        obs_sel   = sel;
        obs_vld   = out_vld;
        obs_alloc = alloc;
        e_sel   = 3'(m_owner);
        e_vld   = m_busy ? in_dv[m_owner] : 1'b0;
        e_alloc = (m_busy && in_dv[m_owner] && rdy) ? (5'b00001 << m_owner) : 5'b00000;
        checks++;
        if (obs_sel !== e_sel) begin
            errors++;
            $display("FAIL %s sel: got %0d expected %0d at %0t", tag, obs_sel, e_sel, $time);
        end
        checks++;
        if (obs_vld !== e_vld) begin
            errors++;
            $display("FAIL %s out_vld: got %b expected %b at %0t", tag, obs_vld, e_vld, $time);
        end
        checks++;
        if (obs_alloc !== e_alloc) begin
            errors++;
            $display("FAIL %s chan_alloc: got %b expected %b at %0t", tag, obs_alloc, e_alloc, $time);
        end
        if (!m_busy) begin
            w = pick_winner();
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
            end
        end else if (in_dv[m_owner] && rdy && (in_id[m_owner] == TAIL || in_id[m_owner] == HT)) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 5;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        drive();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_const(input string tag, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        cycle("reset_idle");
        put(2, HEAD, 0);
        cycle("reset_req");
        drive();
        // assert reset mid-packet, away from any clock edge
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_const("reset_async_sel", {2'b00, sel}, 5'd0);
        check_const("reset_async_vld", {4'b0000, out_vld}, 5'd0);
        check_const("reset_async_alloc", alloc, 5'b00000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        set_idle();
        cycle("reset_after");
    endtask

    task automatic test_single_packet();
        do_reset();
        put(2, HEAD, 0);
        cycle("single_req");
        cycle("single_head");
        check_const("single_head_sel", {2'b00, obs_sel}, 5'd2);
        check_const("single_head_alloc", obs_alloc, 5'b00100);
        put(2, BODY, 0);
        cycle("single_body");
        check_const("single_body_alloc", obs_alloc, 5'b00100);
        put(2, TAIL, 0);
        cycle("single_tail");
        check_const("single_tail_alloc", obs_alloc, 5'b00100);
        clr(2);
        cycle("single_done");
        check_const("single_done_vld", {4'b0000, obs_vld}, 5'd0);
    endtask

    task automatic test_back_pressure();
        do_reset();
        put(2, HEAD, 0);
        cycle("bp_req");
        cycle("bp_head");
        put(2, BODY, 0);
        rdy = 1'b0;
        cycle("bp_stall0");
        check_const("bp_stall_alloc", obs_alloc, 5'b00000);
        check_const("bp_stall_sel", {2'b00, obs_sel}, 5'd2);
        cycle("bp_stall1");
        check_const("bp_stall_vld", {4'b0000, obs_vld}, 5'd1);
        rdy = 1'b1;
        cycle("bp_body");
        put(2, TAIL, 0);
        cycle("bp_tail");
        check_const("bp_tail_alloc", obs_alloc, 5'b00100);
        clr(2);
        cycle("bp_done");
    endtask

    task automatic test_route_mismatch();
        do_reset();
        put(1, HEAD, 3);
        for (int k = 0; k < 3; k++) begin
            cycle("mismatch");
            check_const("mismatch_alloc", obs_alloc, 5'b00000);
        end
        clr(1);
    endtask

    task automatic test_contention();
        int got[$];
        int want[4];
`ifdef ALLOC_RR_EN
        want = '{0, 3, 0, 3};
`else
        want = '{0, 0, 0, 0};
`endif
        do_reset();
        put(0, HT, 0);
        put(3, HT, 0);
        for (int k = 0; k < 8; k++) begin
            cycle("contention");
            if (obs_vld === 1'b1) got.push_back(int'(obs_sel));
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d expected 4", got.size());
        end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            checks++;
            if (got[k] != want[k]) begin
                errors++;
                $display("FAIL contention_grant%0d: got %0d expected %0d", k, got[k], want[k]);
            end
        end
        set_idle();
        cycle("contention_end");
    endtask

    task automatic test_lock();
        do_reset();
        put(1, HEAD, 0);
        cycle("lock_req1");
        put(4, HEAD, 0);
        cycle("lock_head1");
        check_const("lock_head1_alloc", obs_alloc, 5'b00010);
        put(1, BODY, 0);
        cycle("lock_body1");
        check_const("lock_body1_alloc", obs_alloc, 5'b00010);
        put(1, TAIL, 0);
        cycle("lock_tail1");
        check_const("lock_tail1_alloc", obs_alloc, 5'b00010);
        clr(1);
        cycle("lock_bubble");
        check_const("lock_bubble_alloc", obs_alloc, 5'b00000);
        cycle("lock_head4");
        check_const("lock_head4_sel", {2'b00, obs_sel}, 5'd4);
        check_const("lock_head4_alloc", obs_alloc, 5'b10000);
        put(4, TAIL, 0);
        cycle("lock_tail4");
        clr(4);
        cycle("lock_done");
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 5; i++) begin
                in_res[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 4));
                in_rv[i]  = ($urandom_range(0, 3) != 0);
                in_id[i]  = 2'($urandom_range(0, 3));
                in_dv[i]  = ($urandom_range(0, 3) != 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle("random");
            checks++;
            if (obs_sel > 3'd4) begin
                errors++;
                $display("FAIL random_sel_range: got %0d expected at most 4", obs_sel);
            end
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        drive();
        model_reset();
        #1;
        test_reset();
        test_single_packet();
        test_back_pressure();
        test_route_mismatch();
        test_contention();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
